mem_stage_pipe: RTL and testbench



---
 rtl/mem_stage_pipe.sv | 170 +++++++++++++++++
 tb/tb_mem_stage_pipe.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_pipe.sv
// Dual-line MEM stage: registers both EX->MEM lines behind a valid/allowin
// handshake, waits for line1's data-SRAM response, aligns/extends load data
// and produces the WB payload plus the per-line forwarding bus.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   line{1,2}_pre_to_now_valid_i    EX line valids
//   next_allowin_i / now_allowin_o  WB accept / this stage accept
//   line{1,2}_now_to_next_valid_o   line valids towards WB
//   excep_flush_i                   exception flush
//   pre_to_ibus                     {line2,line1} EX->MEM payload
//   data_ok_i, rdata_i              SRAM response pulse and read data
//   to_next_obus                    {line2,line1} MEM->WB payload
//   forward_obus                    {line2,line1} MEM forwarding bus
module mem_stage_pipe #(
  parameter int unsigned LINE_IN_W  = 77,
  parameter int unsigned LINE_OUT_W = 70,
  parameter int unsigned LINE_FWD_W = 40
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    line1_pre_to_now_valid_i,
  input  logic                    line2_pre_to_now_valid_i,
  input  logic                    next_allowin_i,
  output logic                    now_allowin_o,
  output logic                    line1_now_to_next_valid_o,
  output logic                    line2_now_to_next_valid_o,
  input  logic                    excep_flush_i,
  input  logic [2*LINE_IN_W-1:0]  pre_to_ibus,
  input  logic                    data_ok_i,
  input  logic [31:0]             rdata_i,
  output logic [2*LINE_OUT_W-1:0] to_next_obus,
  output logic [2*LINE_FWD_W-1:0] forward_obus
);

  logic                 l1_valid;
  logic                 l2_valid;
  logic [LINE_IN_W-1:0] l1_bus;
  logic [LINE_IN_W-1:0] l2_bus;
  logic                 resp_got;
  logic [31:0]          resp_data;
  logic                 discard;

  // Line1 field decode
  logic        l1_mem_req;
  logic        l1_mem_load;
  logic [1:0]  l1_size;
  logic        l1_unsigned;
  logic [1:0]  l1_addr_low;
  logic [4:0]  l1_rd;
  logic        l1_rd_we;
  logic [31:0] l1_alu;
  logic [31:0] l1_pc;

  assign l1_mem_req  = l1_bus[0];
  assign l1_mem_load = l1_bus[1];
  assign l1_size     = l1_bus[3:2];
  assign l1_unsigned = l1_bus[4];
  assign l1_addr_low = l1_bus[6:5];
  assign l1_rd       = l1_bus[11:7];
  assign l1_rd_we    = l1_bus[12];
  assign l1_alu      = l1_bus[44:13];
  assign l1_pc       = l1_bus[76:45];

  // Line2 is ALU-only; its memory fields are never looked at
  logic [4:0]  l2_rd;
  logic        l2_rd_we;
  logic [31:0] l2_alu;
  logic [31:0] l2_pc;
  logic [6:0]  unused_l2_mem;

  assign l2_rd         = l2_bus[11:7];
  assign l2_rd_we      = l2_bus[12];
  assign l2_alu        = l2_bus[44:13];
  assign l2_pc         = l2_bus[76:45];
  assign unused_l2_mem = l2_bus[6:0];

  // A response seen while discard is set belongs to a flushed request
  logic resp_ok;
  logic l1_wait;
  logic l1_ready;
  logic l1_is_load;

  assign resp_ok    = data_ok_i && !discard;
  assign l1_wait    = l1_valid && l1_mem_req && !resp_got;
  assign l1_ready   = !(l1_wait && !resp_ok);
  assign l1_is_load = l1_mem_req && l1_mem_load;

  assign now_allowin_o             = !(l1_valid || l2_valid) || (l1_ready && next_allowin_i);
  assign line1_now_to_next_valid_o = l1_valid && l1_ready && !excep_flush_i;
  assign line2_now_to_next_valid_o = l2_valid && l1_ready && !excep_flush_i;

  // Load data alignment and extension
  logic [31:0] load_raw;
  logic [31:0] load_shift;
  logic [31:0] load_aligned;
  logic        load_ext;

  always_comb begin
    load_raw     = resp_got ? resp_data : rdata_i;
    load_shift   = load_raw;
    load_ext     = 1'b0;
    load_aligned = load_raw;
    case (l1_size)
      2'd0: begin
        load_shift   = load_raw >> {l1_addr_low, 3'b000};
        load_ext     = !l1_unsigned && load_shift[7];
        load_aligned = {{24{load_ext}}, load_shift[7:0]};
      end
      2'd1: begin
        load_shift   = load_raw >> {l1_addr_low[1], 4'b0000};
        load_ext     = !l1_unsigned && load_shift[15];
        load_aligned = {{16{load_ext}}, load_shift[15:0]};
      end
      default: load_aligned = load_raw;
    endcase
  end

  logic [31:0] l1_wb_data;
  logic        l1_data_ready;
  logic        l1_fwd_valid;
  logic        l2_fwd_valid;

  assign l1_wb_data    = l1_is_load ? load_aligned : l1_alu;
  assign l1_data_ready = l1_valid && !(l1_is_load && !(resp_got || resp_ok));
  assign l1_fwd_valid  = l1_valid && !excep_flush_i;
  assign l2_fwd_valid  = l2_valid && !excep_flush_i;

  assign to_next_obus = {l2_pc, l2_alu, l2_rd_we, l2_rd,
                         l1_pc, l1_wb_data, l1_rd_we, l1_rd};

  assign forward_obus = {l2_fwd_valid, l2_rd_we, l2_rd, l2_alu, l2_valid,
                         l1_fwd_valid, l1_rd_we, l1_rd, l1_wb_data, l1_data_ready};

  // Stage registers: flush beats capture; a held line buffers its response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l1_valid  <= 1'b0;
      l2_valid  <= 1'b0;
      l1_bus    <= '0;
      l2_bus    <= '0;
      resp_got  <= 1'b0;
      resp_data <= '0;
    end else if (excep_flush_i) begin
      l1_valid <= 1'b0;
      l2_valid <= 1'b0;
      resp_got <= 1'b0;
    end else if (now_allowin_o) begin
      l1_valid <= line1_pre_to_now_valid_i;
      l2_valid <= line2_pre_to_now_valid_i;
      l1_bus   <= pre_to_ibus[LINE_IN_W-1:0];
      l2_bus   <= pre_to_ibus[2*LINE_IN_W-1:LINE_IN_W];
      resp_got <= 1'b0;
    end else if (l1_wait && resp_ok) begin
      resp_got  <= 1'b1;
      resp_data <= rdata_i;
    end
  end

  // Tracks one in-flight response whose requester was flushed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      discard <= 1'b0;
    end else if (discard && data_ok_i) begin
      discard <= 1'b0;
    end else if (excep_flush_i && l1_wait && !data_ok_i) begin
      discard <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Directed bench for mem_stage_pipe: inputs change on the falling edge,
// outputs are compared 1 ns later, well away from the rising edge.
module tb_mem_stage_pipe;

  localparam int unsigned IW = 77;
  localparam int unsigned OW = 70;
  localparam int unsigned FW = 40;

  logic              clk;
  logic              rst_n;
  logic              l1v_i;
  logic              l2v_i;
  logic              nxt;
  logic              allowin;
  logic              v1;
  logic              v2;
  logic              flush;
  logic [2*IW-1:0]   ibus;
  logic              dok;
  logic [31:0]       rdata;
  logic [2*OW-1:0]   obus;
  logic [2*FW-1:0]   fwd;

  int total;
  int bad;

  mem_stage_pipe dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .line1_pre_to_now_valid_i  (l1v_i),
    .line2_pre_to_now_valid_i  (l2v_i),
    .next_allowin_i            (nxt),
    .now_allowin_o             (allowin),
    .line1_now_to_next_valid_o (v1),
    .line2_now_to_next_valid_o (v2),
    .excep_flush_i             (flush),
    .pre_to_ibus               (ibus),
    .data_ok_i                 (dok),
    .rdata_i                   (rdata),
    .to_next_obus              (obus),
    .forward_obus              (fwd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [IW-1:0] mk_in(input logic req, input logic ld,
      input logic [1:0] sz, input logic uns, input logic [1:0] al,
      input logic [4:0] rd, input logic we, input logic [31:0] alu,
      input logic [31:0] pc);
    return {pc, alu, we, rd, al, uns, sz, ld, req};
  endfunction

  function automatic logic [OW-1:0] mk_out(input logic [31:0] pc,
      input logic [31:0] wb, input logic we, input logic [4:0] rd);
    return {pc, wb, we, rd};
  endfunction

  function automatic logic [FW-1:0] mk_fwd(input logic v, input logic we,
      input logic [4:0] rd, input logic [31:0] data, input logic rdy);
    return {v, we, rd, data, rdy};
  endfunction

  task automatic chk(input string tag, input logic [139:0] got,
      input logic [139:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    l1v_i = 1'b0;
    l2v_i = 1'b0;
    nxt   = 1'b1;
    flush = 1'b0;
    ibus  = '0;
    dok   = 1'b0;
    rdata = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_allowin", 140'(allowin), 140'(1));
    chk("rst_v1", 140'(v1), 140'(0));
    chk("rst_v2", 140'(v2), 140'(0));
    chk("rst_obus", 140'(obus), 140'(0));
    chk("rst_fwd", 140'(fwd), 140'(0));

    // T1: both lines ALU-only
    @(negedge clk);
    rst_n = 1'b1;
    l1v_i = 1'b1;
    l2v_i = 1'b1;
    ibus  = {mk_in(0, 0, 2'd0, 0, 2'd0, 5'd6, 1, 32'h3333_4444, 32'h8000_0004),
             mk_in(0, 0, 2'd0, 0, 2'd0, 5'd5, 1, 32'h1111_2222, 32'h8000_0000)};
    #1 chk("t1_allowin_empty", 140'(allowin), 140'(1));
    @(negedge clk);
    l1v_i = 1'b0;
    l2v_i = 1'b0;
    #1;
    chk("t1_v1", 140'(v1), 140'(1));
    chk("t1_v2", 140'(v2), 140'(1));
    chk("t1_obus", 140'(obus),
        140'({mk_out(32'h8000_0004, 32'h3333_4444, 1, 5'd6),
              mk_out(32'h8000_0000, 32'h1111_2222, 1, 5'd5)}));
    chk("t1_fwd1", 140'(fwd[39:0]), 140'(mk_fwd(1, 1, 5'd5, 32'h1111_2222, 1)));
    chk("t1_allowin", 140'(allowin), 140'(1));

    // T2: signed byte load, addr_low=3, response after two wait cycles
    @(negedge clk);
    l1v_i = 1'b1;
    l2v_i = 1'b1;
    ibus  = {mk_in(0, 0, 2'd0, 0, 2'd0, 5'd8, 1, 32'h0000_0055, 32'h8000_0014),
             mk_in(1, 1, 2'd0, 0, 2'd3, 5'd7, 1, 32'h1000_0003, 32'h8000_0010)};
    @(negedge clk);
    l1v_i = 1'b0;
    l2v_i = 1'b0;
    #1;
    chk("t2_wait1_allowin", 140'(allowin), 140'(0));
    chk("t2_wait1_v1", 140'(v1), 140'(0));
    chk("t2_wait1_v2", 140'(v2), 140'(0));
    chk("t2_wait1_rdy", 140'(fwd[0]), 140'(0));
    @(negedge clk);
    #1 chk("t2_wait2_allowin", 140'(allowin), 140'(0));
    @(negedge clk);
    dok   = 1'b1;
    rdata = 32'h80FF_FFFF;
    #1;
    chk("t2_v1", 140'(v1), 140'(1));
    chk("t2_v2", 140'(v2), 140'(1));
    chk("t2_obus", 140'(obus),
        140'({mk_out(32'h8000_0014, 32'h0000_0055, 1, 5'd8),
              mk_out(32'h8000_0010, 32'hFFFF_FF80, 1, 5'd7)}));
    chk("t2_allowin", 140'(allowin), 140'(1));

    // T3: unsigned half load, addr_low=2, response while WB stalls
    @(negedge clk);
    dok   = 1'b0;
    l1v_i = 1'b1;
    ibus  = {77'(0), mk_in(1, 1, 2'd1, 1, 2'd2, 5'd9, 1, 32'h2000_0002, 32'h8000_0020)};
    @(negedge clk);
    l1v_i = 1'b0;
    nxt   = 1'b0;
    dok   = 1'b1;
    rdata = 32'h9ABC_1234;
    #1;
    chk("t3_stall_allowin", 140'(allowin), 140'(0));
    chk("t3_stall_v1", 140'(v1), 140'(1));
    chk("t3_stall_wb", 140'(obus[37:6]), 140'(32'h0000_9ABC));
    @(negedge clk);
    dok   = 1'b0;
    rdata = 32'hDEAD_BEEF;
    nxt   = 1'b1;
    #1;
    chk("t3_buf_v1", 140'(v1), 140'(1));
    chk("t3_buf_wb", 140'(obus[37:6]), 140'(32'h0000_9ABC));
    chk("t3_buf_rdy", 140'(fwd[0]), 140'(1));
    chk("t3_allowin", 140'(allowin), 140'(1));

    // T4: flush while waiting, stale response dropped, next load correct
    @(negedge clk);
    rdata = '0;
    l1v_i = 1'b1;
    l2v_i = 1'b1;
    ibus  = {mk_in(0, 0, 2'd0, 0, 2'd0, 5'd3, 1, 32'h0000_0077, 32'h8000_0034),
             mk_in(1, 1, 2'd2, 0, 2'd0, 5'd10, 1, 32'h3000_0000, 32'h8000_0030)};
    @(negedge clk);
    l1v_i = 1'b0;
    l2v_i = 1'b0;
    #1 chk("t4_wait_allowin", 140'(allowin), 140'(0));
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("t4_flush_v1", 140'(v1), 140'(0));
    chk("t4_flush_v2", 140'(v2), 140'(0));
    chk("t4_flush_fwdv", 140'(fwd[39]), 140'(0));
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("t4_after_v1", 140'(v1), 140'(0));
    chk("t4_after_v2", 140'(v2), 140'(0));
    chk("t4_after_allowin", 140'(allowin), 140'(1));
    l1v_i = 1'b1;
    ibus  = {77'(0), mk_in(1, 1, 2'd2, 0, 2'd0, 5'd11, 1, 32'h4000_0000, 32'h8000_0040)};
    @(negedge clk);
    l1v_i = 1'b0;
    dok   = 1'b1;
    rdata = 32'hBAD0_BAD0;
    #1;
    chk("t4_stale_v1", 140'(v1), 140'(0));
    chk("t4_stale_allowin", 140'(allowin), 140'(0));
    @(negedge clk);
    rdata = 32'h1234_5678;
    #1;
    chk("t4_new_v1", 140'(v1), 140'(1));
    chk("t4_new_wb", 140'(obus[37:6]), 140'(32'h1234_5678));

    // T5: flush together with data_ok, no discard afterwards
    @(negedge clk);
    dok   = 1'b0;
    l1v_i = 1'b1;
    ibus  = {77'(0), mk_in(1, 1, 2'd2, 0, 2'd0, 5'd12, 1, 32'h5000_0000, 32'h8000_0050)};
    @(negedge clk);
    l1v_i = 1'b0;
    flush = 1'b1;
    dok   = 1'b1;
    rdata = 32'hAAAA_AAAA;
    #1 chk("t5_flush_v1", 140'(v1), 140'(0));
    @(negedge clk);
    flush = 1'b0;
    dok   = 1'b0;
    #1 chk("t5_allowin", 140'(allowin), 140'(1));
    l1v_i = 1'b1;
    ibus  = {77'(0), mk_in(1, 1, 2'd2, 0, 2'd0, 5'd13, 1, 32'h5100_0000, 32'h8000_0060)};
    @(negedge clk);
    l1v_i = 1'b0;
    dok   = 1'b1;
    rdata = 32'h0BAD_F00D;
    #1;
    chk("t5_v1", 140'(v1), 140'(1));
    chk("t5_obus1", 140'(obus[69:0]),
        140'(mk_out(32'h8000_0060, 32'h0BAD_F00D, 1, 5'd13)));

    // T6: async reset mid-wait clears valids and a pending discard
    @(negedge clk);
    dok   = 1'b0;
    l1v_i = 1'b1;
    ibus  = {77'(0), mk_in(1, 1, 2'd2, 0, 2'd0, 5'd14, 1, 32'h6000_0000, 32'h8000_0070)};
    @(negedge clk);
    l1v_i = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    l1v_i = 1'b1;
    ibus  = {77'(0), mk_in(1, 1, 2'd2, 0, 2'd0, 5'd15, 1, 32'h6100_0000, 32'h8000_0080)};
    @(negedge clk);
    l1v_i = 1'b0;
    #1 chk("t6_wait_allowin", 140'(allowin), 140'(0));
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_allowin", 140'(allowin), 140'(1));
    chk("t6_rst_v1", 140'(v1), 140'(0));
    chk("t6_rst_obus", 140'(obus), 140'(0));
    chk("t6_rst_fwd", 140'(fwd), 140'(0));
    @(negedge clk);
    rst_n = 1'b1;
    l1v_i = 1'b1;
    ibus  = {77'(0), mk_in(1, 1, 2'd2, 0, 2'd0, 5'd16, 1, 32'h6200_0000, 32'h8000_0090)};
    @(negedge clk);
    l1v_i = 1'b0;
    dok   = 1'b1;
    rdata = 32'hCAFE_0001;
    #1;
    chk("t6_v1", 140'(v1), 140'(1));
    chk("t6_wb", 140'(obus[37:6]), 140'(32'hCAFE_0001));

    @(negedge clk);
    dok = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
